instr_issue_sequencer: RTL and testbench
========================================

// Module: instr_issue_sequencer
// PURPOSE
//  Buffers 32-bit instructions from a host/loader and issues at most one per clock on Instr to the
//  datapath + controller pair (opcode Instr[31:26] decoded downstream).
//  Detects load-use hazards and inserts NOP bubbles (32'd0) instead of the dependent instruction.
//  Keeps issue/bubble statistics and replaces the hand-driven instruction stream in processor-level benches.
// PARAMETERS
//  DEPTH     8  instruction FIFO entries (power of 2, >=2)
//  LOAD_LAT  1  bubbles required between an LW and a consumer of its dest (0..3; 0 disables hazard check)
//  CNT_W     16 width of statistic counters
// PORTS
//  clk           in   1      clock, all state updates on posedge
//  rst           in   1      synchronous, active-high reset
//  en            in   1      1: issuing allowed; 0: hold FIFO, drive NOP
//  flush         in   1      synchronous clear of FIFO and hazard history (counters kept)
//  in_instr      in   32     instruction to enqueue
//  in_valid      in   1      in_instr valid
//  in_ready      out  1      FIFO can accept (push when in_valid & in_ready)
//  Instr         out  32     registered instruction to datapath/controller; 32'd0 = bubble
//  issue_valid   out  1      registered; 1 when Instr holds a real (non-bubble) instruction
//  busy          out  1      FIFO non-empty or state != S_IDLE
//  err_illegal   out  1      sticky; set when an unknown opcode reaches head
//  issued_cnt    out  CNT_W  real instructions issued, wraps
//  bubble_cnt    out  CNT_W  hazard bubbles inserted, wraps
// BEHAVIOUR
//  Reset: FIFO empty, history cleared, state S_IDLE, Instr=0, issue_valid=0, err_illegal=0,
//   counters=0, in_ready=1 from the first cycle after reset.
//  Opcodes: ADD=6'b000001, LW=6'b000010, SW=6'b000100. Fields: rs=[25:21], rt=[20:16], rd=[15:11].
//   Sources: ADD rs,rt; LW rs; SW rs,rt. Dest: ADD rd; LW rt; SW none. Register 0 compared like any other.
//  FIFO: in_ready = (count < DEPTH); computed from current count only, so no push while full even if
//   popping that cycle. Push and pop in the same cycle are allowed when not full. No overflow, no underflow.
//  History: LOAD_LAT-deep shift register of {valid, dest}. It shifts every cycle in S_ISSUE/S_STALL.
//   The entry inserted is {1, rt} on an LW issue and {0, x} otherwise (bubble, non-LW, idle).
//  hazard = head is valid, and any history entry is valid with its dest equal to a source of head.
//  FSM (registered):
//   S_IDLE : Instr=0. If en & FIFO non-empty, enter S_ISSUE. Issue happens next cycle, not in this one.
//   S_ISSUE: if !en or empty: Instr=0, go to S_IDLE.
//            else if hazard: Instr=0, bubble_cnt++, go to S_STALL, no pop.
//            else: pop head, Instr=head, issue_valid=1, issued_cnt++.
//   S_STALL: same evaluation as S_ISSUE. History keeps shifting, so after at most LOAD_LAT bubbles
//            hazard clears and the head issues. Return to S_ISSUE on that issue.
//   The history is cleared on leaving to S_IDLE.
//  Latency: instruction pushed at edge N into an empty FIFO while in S_ISSUE appears on Instr after edge N+1.
//  Illegal opcode at head: popped, Instr=0, issue_valid=0, err_illegal<=1, no counter change, no hazard check.
//  flush (priority over push/pop, below rst): next edge empties FIFO and history and forces S_IDLE, Instr=0.
//   err_illegal and counters are unaffected. An in_valid push in the same cycle is dropped.
//  rst mid-stream: all state returns to reset values at that edge. In-flight FIFO contents are lost.
//  Counters wrap modulo 2^CNT_W with no saturation.
// TESTING
//  1 Reset then push LW r1<-0(r0), ADD r3=r1+r1 (LOAD_LAT=1) -> Instr: LW, 0, ADD; bubble_cnt=1, issued_cnt=2.
//  2 Independent stream ADD,SW,LW (no dependences) pushed back-to-back -> one issue per cycle, bubble_cnt=0.
//  3 Push 9 instrs with en=0, DEPTH=8 -> in_ready low after 8th; 9th held by source; en=1 drains all 9 in order.
//  4 LOAD_LAT=2, LW r5 then SW reading r5 -> exactly 2 NOPs before SW; LOAD_LAT=0 -> no NOPs.
//  5 Opcode 6'b111111 in stream -> err_illegal=1 sticky, neighbours issue normally, issued_cnt excludes it.
//  6 flush with 4 queued and a pending hazard -> next cycle busy=0, Instr=0; counters retained; rst mid-run -> all zero.

Source files
------------

// File: rtl/instr_issue_sequencer.sv
// instr_issue_sequencer
//   Buffers 32-bit instructions from a host/loader in a small FIFO and issues
//   at most one per clock on Instr. A load-use hazard against a recent LW
//   replaces the dependent instruction with a NOP bubble (32'd0) until the
//   load result is far enough behind.
//
// Ports
//   clk          clock, all state updates on posedge
//   rst          synchronous active-high reset
//   en           1: issuing allowed; 0: hold FIFO, drive NOP
//   flush        synchronous clear of FIFO and hazard history (counters kept)
//   in_instr     instruction to enqueue
//   in_valid     in_instr valid
//   in_ready     FIFO can accept (push when in_valid & in_ready)
//   Instr        registered instruction to datapath; 32'd0 = bubble
//   issue_valid  registered; 1 when Instr holds a real instruction
//   busy         FIFO non-empty or FSM not idle
//   err_illegal  sticky; set when an unknown opcode reaches the head
//   issued_cnt   real instructions issued (wraps)
//   bubble_cnt   hazard bubbles inserted (wraps)
//
// FSM states
//   state   | meaning
//   S_IDLE  | nothing issuing; Instr=0; waits for en and a queued instruction
//   S_ISSUE | issuing the FIFO head each cycle
//   S_STALL | last cycle was a hazard bubble; head re-evaluated each cycle
module instr_issue_sequencer #(
  parameter int DEPTH    = 8,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [31:0]      in_instr,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      Instr,
  output logic             issue_valid,
  output logic             busy,
  output logic             err_illegal,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  // Keep at least one history slot so the arrays stay legal when LOAD_LAT=0.
  localparam int HIST = (LOAD_LAT == 0) ? 1 : LOAD_LAT;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  localparam logic [5:0] OP_ADD = 6'b000001;
  localparam logic [5:0] OP_LW  = 6'b000010;
  localparam logic [5:0] OP_SW  = 6'b000100;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_STALL} state_t;

  logic [31:0]      r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  state_t           r_state;
  logic             r_hist_v [HIST];
  logic [4:0]       r_hist_d [HIST];
  logic [31:0]      r_instr;
  logic             r_issue_valid;
  logic             r_err;
  logic [CNT_W-1:0] r_issued, r_bubble;

  logic        w_empty, w_push;
  logic [31:0] w_head;
  logic [5:0]  w_op;
  logic [4:0]  w_rs, w_rt;
  logic        w_legal, w_is_lw, w_uses_rt, w_hazard;
  state_t      w_state_nxt;
  logic [31:0] w_instr_nxt;
  logic        w_valid_nxt, w_pop, w_bubble, w_illegal;
  logic        w_hist_shift, w_hist_clr, w_ins_v;
  logic [4:0]  w_ins_d;

  assign w_empty   = (r_count == '0);
  assign in_ready  = (r_count < C_DEPTH);
  // A push in a flush cycle is dropped.
  assign w_push    = in_valid && in_ready && !flush;
  assign w_head    = r_mem[r_rd_ptr];
  assign w_op      = w_head[31:26];
  assign w_rs      = w_head[25:21];
  assign w_rt      = w_head[20:16];
  assign w_is_lw   = (w_op == OP_LW);
  assign w_uses_rt = (w_op == OP_ADD) || (w_op == OP_SW);
  assign w_legal   = (w_op == OP_ADD) || w_is_lw || (w_op == OP_SW);

  always_comb begin
    w_hazard = 1'b0;
    if (LOAD_LAT != 0 && !w_empty) begin
      for (int i = 0; i < HIST; i++) begin
        if (r_hist_v[i] && ((r_hist_d[i] == w_rs) || (w_uses_rt && (r_hist_d[i] == w_rt))))
          w_hazard = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_instr_nxt  = '0;
    w_valid_nxt  = 1'b0;
    w_pop        = 1'b0;
    w_bubble     = 1'b0;
    w_illegal    = 1'b0;
    w_hist_shift = 1'b0;
    w_hist_clr   = 1'b0;
    w_ins_v      = 1'b0;
    w_ins_d      = '0;
    case (r_state)
      S_IDLE: begin
        if (en && !w_empty) w_state_nxt = S_ISSUE;
      end
      S_ISSUE, S_STALL: begin
        if (!en || w_empty) begin
          w_state_nxt = S_IDLE;
          w_hist_clr  = 1'b1;
        end else begin
          w_hist_shift = 1'b1;
          if (!w_legal) begin
            // Unknown opcode is discarded without a hazard check.
            w_pop       = 1'b1;
            w_illegal   = 1'b1;
            w_state_nxt = S_ISSUE;
          end else if (w_hazard) begin
            w_bubble    = 1'b1;
            w_state_nxt = S_STALL;
          end else begin
            w_pop       = 1'b1;
            w_instr_nxt = w_head;
            w_valid_nxt = 1'b1;
            w_state_nxt = S_ISSUE;
            if (w_is_lw) begin
              w_ins_v = 1'b1;
              w_ins_d = w_rt;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr_ptr] <= in_instr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_state       <= S_IDLE;
      r_instr       <= '0;
      r_issue_valid <= 1'b0;
      r_err         <= 1'b0;
      r_issued      <= '0;
      r_bubble      <= '0;
      for (int i = 0; i < HIST; i++) begin
        r_hist_v[i] <= 1'b0;
        r_hist_d[i] <= '0;
      end
    end else if (flush) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_state       <= S_IDLE;
      r_instr       <= '0;
      r_issue_valid <= 1'b0;
      for (int i = 0; i < HIST; i++) begin
        r_hist_v[i] <= 1'b0;
        r_hist_d[i] <= '0;
      end
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      r_state       <= w_state_nxt;
      r_instr       <= w_instr_nxt;
      r_issue_valid <= w_valid_nxt;
      if (w_illegal)   r_err    <= 1'b1;
      if (w_valid_nxt) r_issued <= r_issued + CNT_W'(1);
      if (w_bubble)    r_bubble <= r_bubble + CNT_W'(1);
      if (w_hist_clr) begin
        for (int i = 0; i < HIST; i++) begin
          r_hist_v[i] <= 1'b0;
          r_hist_d[i] <= '0;
        end
      end else if (w_hist_shift) begin
        for (int i = HIST - 1; i > 0; i--) begin
          r_hist_v[i] <= r_hist_v[i-1];
          r_hist_d[i] <= r_hist_d[i-1];
        end
        r_hist_v[0] <= w_ins_v;
        r_hist_d[0] <= w_ins_d;
      end
    end
  end

  assign Instr       = r_instr;
  assign issue_valid = r_issue_valid;
  assign err_illegal = r_err;
  assign issued_cnt  = r_issued;
  assign bubble_cnt  = r_bubble;
  assign busy        = !w_empty || (r_state != S_IDLE);

endmodule

// File: tb/tb_instr_issue_sequencer.sv
module tb_instr_issue_sequencer;

  localparam logic [5:0] OP_ADD = 6'b000001;
  localparam logic [5:0] OP_LW  = 6'b000010;
  localparam logic [5:0] OP_SW  = 6'b000100;

  logic        clk = 1'b0;
  logic        rst, en, flush, in_valid;
  logic [31:0] in_instr;

  logic        rdy0, rdy1, rdy2;
  logic [31:0] instr0, instr1, instr2;
  logic        iv0, iv1, iv2;
  logic        busy0, busy1, busy2;
  logic        err0, err1, err2;
  logic [15:0] iss0, iss1, iss2;
  logic [15:0] bub0, bub1, bub2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_issue_sequencer #(.DEPTH(8), .LOAD_LAT(0), .CNT_W(16)) u_l0 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_instr(in_instr), .in_valid(in_valid),
    .in_ready(rdy0), .Instr(instr0), .issue_valid(iv0), .busy(busy0), .err_illegal(err0),
    .issued_cnt(iss0), .bubble_cnt(bub0));

  instr_issue_sequencer #(.DEPTH(8), .LOAD_LAT(1), .CNT_W(16)) u_l1 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_instr(in_instr), .in_valid(in_valid),
    .in_ready(rdy1), .Instr(instr1), .issue_valid(iv1), .busy(busy1), .err_illegal(err1),
    .issued_cnt(iss1), .bubble_cnt(bub1));

  instr_issue_sequencer #(.DEPTH(8), .LOAD_LAT(2), .CNT_W(16)) u_l2 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_instr(in_instr), .in_valid(in_valid),
    .in_ready(rdy2), .Instr(instr2), .issue_valid(iv2), .busy(busy2), .err_illegal(err2),
    .issued_cnt(iss2), .bubble_cnt(bub2));

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt);
    return {op, rs, rt, 16'd0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  logic [31:0] lw1, add3, a2, s2, l2i, a2b, ill, pa, pb;
  logic [31:0] lw5, sw5, lw6, d1, d2;
  logic [31:0] t3_vec [9];
  logic [31:0] e0 [4];
  logic [31:0] e1 [4];
  logic [31:0] e2 [4];
  logic        acc;
  int          got;

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    chk("rst_instr", instr1, 32'd0);
    chk("rst_iv", {31'd0, iv1}, 32'd0);
    chk("rst_ready", {31'd0, rdy1}, 32'd1);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_err", {31'd0, err1}, 32'd0);
    chk("rst_iss", {16'd0, iss1}, 32'd0);
    chk("rst_bub", {16'd0, bub1}, 32'd0);
    chk("rst_ready_l0", {31'd0, rdy0}, 32'd1);
    chk("rst_ready_l2", {31'd0, rdy2}, 32'd1);
    chk("rst_iv_l0", {31'd0, iv0}, 32'd0);
    chk("rst_iv_l2", {31'd0, iv2}, 32'd0);

    // 1: LW r1 <- 0(r0); ADD r3 = r1 + r1
    lw1  = enc_i(OP_LW, 5'd0, 5'd1);
    add3 = enc_r(OP_ADD, 5'd1, 5'd1, 5'd3);
    en = 1'b1;
    in_valid = 1'b1; in_instr = lw1;  tick();
    chk("t1_idle0", instr1, 32'd0);
    in_instr = add3; tick();
    chk("t1_idle1", instr1, 32'd0);
    in_valid = 1'b0; tick();
    chk("t1_lw", instr1, lw1);
    chk("t1_lw_iv", {31'd0, iv1}, 32'd1);
    tick();
    chk("t1_bubble", instr1, 32'd0);
    chk("t1_bubble_iv", {31'd0, iv1}, 32'd0);
    chk("t1_bub_cnt_mid", {16'd0, bub1}, 32'd1);
    tick();
    chk("t1_add", instr1, add3);
    chk("t1_iss", {16'd0, iss1}, 32'd2);
    chk("t1_bub", {16'd0, bub1}, 32'd1);
    tick();
    chk("t1_busy_end", {31'd0, busy1}, 32'd0);

    // 2: independent stream, plus a push into an empty FIFO while issuing
    a2  = enc_r(OP_ADD, 5'd5, 5'd6, 5'd4);
    s2  = enc_i(OP_SW, 5'd8, 5'd7);
    l2i = enc_i(OP_LW, 5'd10, 5'd9);
    a2b = enc_r(OP_ADD, 5'd11, 5'd12, 5'd13);
    in_valid = 1'b1; in_instr = a2; tick();
    in_instr = s2;  tick();
    in_instr = l2i; tick();
    chk("t2_add", instr1, a2);
    in_valid = 1'b0; tick();
    chk("t2_sw", instr1, s2);
    in_valid = 1'b1; in_instr = a2b; tick();
    chk("t2_lw", instr1, l2i);
    in_valid = 1'b0; tick();
    chk("t2_latency", instr1, a2b);
    tick();
    chk("t2_idle", instr1, 32'd0);
    chk("t2_iss", {16'd0, iss1}, 32'd6);
    chk("t2_bub", {16'd0, bub1}, 32'd1);

    // 3: fill with en=0, 9th held by source, then drain in order
    en = 1'b0;
    for (int i = 0; i < 9; i++) t3_vec[i] = enc_r(OP_ADD, 5'(i + 1), 5'(i + 2), 5'(i + 3));
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_instr = t3_vec[i]; tick();
      if (i == 6) chk("t3_ready_at7", {31'd0, rdy1}, 32'd1);
    end
    chk("t3_full", {31'd0, rdy1}, 32'd0);
    in_instr = t3_vec[8]; in_valid = 1'b1;
    tick(); tick();
    chk("t3_full_hold", {31'd0, rdy1}, 32'd0);
    chk("t3_no_issue", {31'd0, iv1}, 32'd0);
    chk("t3_busy", {31'd0, busy1}, 32'd1);
    en = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 9; cyc++) begin
      acc = in_valid && rdy1;
      tick();
      if (acc) in_valid = 1'b0;
      if (iv1) begin
        chk("t3_order", instr1, t3_vec[got]);
        got++;
      end
    end
    chk("t3_drained", got, 32'd9);
    chk("t3_iss", {16'd0, iss1}, 32'd15);
    in_valid = 1'b0;
    tick(); tick();

    // 4: LW r5 then SW reading r5, across LOAD_LAT 0/1/2
    rst = 1'b1; tick(); rst = 1'b0;
    lw5 = enc_i(OP_LW, 5'd0, 5'd5);
    sw5 = enc_i(OP_SW, 5'd2, 5'd5);
    e0[0] = lw5; e0[1] = sw5;  e0[2] = 32'd0; e0[3] = 32'd0;
    e1[0] = lw5; e1[1] = 32'd0; e1[2] = sw5;  e1[3] = 32'd0;
    e2[0] = lw5; e2[1] = 32'd0; e2[2] = 32'd0; e2[3] = sw5;
    in_valid = 1'b1; in_instr = lw5; tick();
    in_instr = sw5; tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t4_lat0", instr0, e0[k]);
      chk("t4_lat1", instr1, e1[k]);
      chk("t4_lat2", instr2, e2[k]);
    end
    tick();
    chk("t4_bub_l0", {16'd0, bub0}, 32'd0);
    chk("t4_bub_l1", {16'd0, bub1}, 32'd1);
    chk("t4_bub_l2", {16'd0, bub2}, 32'd2);
    chk("t4_iss_l2", {16'd0, iss2}, 32'd2);
    chk("t4_busy_l0", {31'd0, busy0}, 32'd0);
    chk("t4_busy_l2", {31'd0, busy2}, 32'd0);

    // 5: illegal opcode between two legal instructions
    pa  = enc_r(OP_ADD, 5'd1, 5'd2, 5'd3);
    pb  = enc_r(OP_ADD, 5'd3, 5'd3, 5'd4);
    ill = {6'b111111, 26'd0};
    in_valid = 1'b1; in_instr = pa; tick();
    in_instr = ill; tick();
    in_instr = pb;  tick();
    chk("t5_a", instr1, pa);
    in_valid = 1'b0; tick();
    chk("t5_ill_instr", instr1, 32'd0);
    chk("t5_ill_iv", {31'd0, iv1}, 32'd0);
    chk("t5_err", {31'd0, err1}, 32'd1);
    tick();
    chk("t5_b", instr1, pb);
    tick(); tick();
    chk("t5_err_sticky", {31'd0, err1}, 32'd1);
    chk("t5_iss", {16'd0, iss1}, 32'd4);
    chk("t5_bub", {16'd0, bub1}, 32'd1);
    chk("t5_err_l0", {31'd0, err0}, 32'd1);
    chk("t5_err_l2", {31'd0, err2}, 32'd1);
    chk("t5_iss_l0", {16'd0, iss0}, 32'd4);
    chk("t5_iss_l2", {16'd0, iss2}, 32'd4);

    // 6: flush with 4 queued and a pending hazard, then rst mid-run
    lw6 = enc_i(OP_LW, 5'd0, 5'd6);
    d1  = enc_r(OP_ADD, 5'd6, 5'd6, 5'd7);
    d2  = enc_r(OP_ADD, 5'd1, 5'd1, 5'd1);
    en = 1'b0;
    in_valid = 1'b1;
    in_instr = lw6; tick();
    in_instr = d1;  tick();
    in_instr = d2;  tick();
    tick();
    tick();
    in_valid = 1'b0;
    en = 1'b1;
    tick();
    chk("t6_enter", instr1, 32'd0);
    tick();
    chk("t6_lw", instr1, lw6);
    chk("t6_iss_pre", {16'd0, iss1}, 32'd5);
    flush = 1'b1; in_valid = 1'b1; in_instr = d2; tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t6_busy", {31'd0, busy1}, 32'd0);
    chk("t6_instr", instr1, 32'd0);
    chk("t6_iv", {31'd0, iv1}, 32'd0);
    chk("t6_ready", {31'd0, rdy1}, 32'd1);
    chk("t6_iss_kept", {16'd0, iss1}, 32'd5);
    chk("t6_bub_kept", {16'd0, bub1}, 32'd1);
    chk("t6_err_kept", {31'd0, err1}, 32'd1);
    tick(); tick();
    chk("t6_push_dropped", {31'd0, busy1}, 32'd0);
    in_valid = 1'b1; in_instr = d1; tick();
    in_valid = 1'b0; tick(); tick();
    chk("t6_hist_cleared", instr1, d1);
    chk("t6_no_bubble", {16'd0, bub1}, 32'd1);
    chk("t6_iss_post", {16'd0, iss1}, 32'd6);

    en = 1'b0;
    in_valid = 1'b1;
    in_instr = pa; tick();
    in_instr = pb; tick();
    in_instr = d2; tick();
    in_valid = 1'b0; en = 1'b1;
    tick(); tick();
    chk("t6_midrun_issue", instr1, pa);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_rst_instr", instr1, 32'd0);
    chk("t6_rst_iv", {31'd0, iv1}, 32'd0);
    chk("t6_rst_err", {31'd0, err1}, 32'd0);
    chk("t6_rst_iss", {16'd0, iss1}, 32'd0);
    chk("t6_rst_bub", {16'd0, bub1}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy1}, 32'd0);
    chk("t6_rst_ready", {31'd0, rdy1}, 32'd1);
    tick(); tick();
    chk("t6_rst_stays_idle", {31'd0, busy1}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
